// File: rtl/video_stream_pkg.sv
`default_nettype none
// ==== video_stream_pkg: shared types/constants for the camera packet path ==== rev 1.0
package video_stream_pkg;

    localparam int DEF_IMG_WIDTH  = 320;
    localparam int DEF_IMG_HEIGHT = 240;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    typedef struct packed {
        logic   sop;
        logic   eop;
        pixel_t pix;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } framer_state_t;

    // Vertical colour bars, left to right.
    localparam logic [11:0] COLOUR_BARS [0:7] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

endpackage
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ==== stream_fifo: first-word-fall-through FIFO of tagged pixels ==== rev 1.0
module stream_fifo
    import video_stream_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  fifo_entry_t wr_entry,
    input  logic        pop,
    output fifo_entry_t rd_entry,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t    mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot being written, so a full FIFO still accepts a push alongside it.
    assign do_push = push && (!full || do_pop);
    assign rd_entry = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_packet_framer.sv
`default_nettype none
// ==== video_packet_framer: camera pixels -> RGB444 sop/eop packet stream ==== rev 1.0
// Optional FRAMER_TEST_PATTERN_EN adds test_pattern_in (colour-bar substitution).
module video_packet_framer
    import video_stream_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef FRAMER_TEST_PATTERN_EN
    input  logic              test_pattern_in,
`endif
    input  logic              frame_start_in,
    input  logic              pix_valid_in,
    input  logic [DATA_W-1:0] pix_data_in,
    input  logic              ready_in,
    output logic              valid_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic [DATA_W-1:0] data_out,
    output logic              overflow_out,
    output logic              frame_err_out
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    framer_state_t  state;
    framer_state_t  next_state;
    logic [XW-1:0]  x_cnt;
    logic [YW-1:0]  y_cnt;
    logic [XW-1:0]  x_cur;
    logic [YW-1:0]  y_cur;
    logic           x_last;
    logic           y_last;
    logic           counted;
    logic           stray;
    logic           stray_seen;
    logic           last_pix;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic           drop;
    pixel_t         pix_sel;
    fifo_entry_t    wr_entry;
    fifo_entry_t    rd_entry;

    // The pixel arriving with frame_start_in is pixel 0 of the new frame.
    assign x_cur    = frame_start_in ? '0 : x_cnt;
    assign y_cur    = frame_start_in ? '0 : y_cnt;
    assign x_last   = (x_cur == XW'(IMG_WIDTH - 1));
    assign y_last   = (y_cur == YW'(IMG_HEIGHT - 1));
    assign counted  = pix_valid_in && ((state == ACTIVE) || frame_start_in);
    assign stray    = pix_valid_in && !frame_start_in && (state != ACTIVE);
    assign last_pix = counted && x_last && y_last;

`ifdef FRAMER_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    assign bar_idx = 3'(32'(x_cur) / (IMG_WIDTH / 8));
    assign pix_sel = test_pattern_in ? pixel_t'(COLOUR_BARS[bar_idx]) : pixel_t'(pix_data_in);
`else
    assign pix_sel = pixel_t'(pix_data_in);
`endif

    assign wr_entry.sop = (x_cur == '0) && (y_cur == '0);
    assign wr_entry.eop = x_last && y_last;
    assign wr_entry.pix = pix_sel;

    assign valid_out = !fifo_empty;
    assign fifo_pop  = valid_out && ready_in;
    assign drop      = counted && fifo_full && !fifo_pop;

    assign startofpacket_out = rd_entry.sop;
    assign endofpacket_out   = rd_entry.eop;
    assign data_out          = DATA_W'(rd_entry.pix);

    stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (counted),
        .wr_entry (wr_entry),
        .pop      (fifo_pop),
        .rd_entry (rd_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        next_state = state;
        if (frame_start_in) next_state = ACTIVE;
        if (last_pix)       next_state = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            x_cnt         <= '0;
            y_cnt         <= '0;
            stray_seen    <= 1'b0;
            overflow_out  <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            state <= next_state;
            if (counted) begin
                x_cnt <= x_last ? '0 : x_cur + 1'b1;
                y_cnt <= x_last ? (y_last ? '0 : y_cur + 1'b1) : y_cur;
            end else if (frame_start_in) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end
            overflow_out  <= drop;
            // Short frame, or the first stray pixel after a frame has ended.
            frame_err_out <= (frame_start_in && (state == ACTIVE)) || (stray && !stray_seen);
            if (frame_start_in)  stray_seen <= 1'b0;
            else if (stray)      stray_seen <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_packet_framer.sv
`default_nettype none
// ==== tb_video_packet_framer: scoreboard bench for video_packet_framer ==== rev 1.0
module tb_video_packet_framer;

    localparam int W     = 16;
    localparam int H     = 4;
    localparam int DEPTH = 8;

    typedef struct {
        logic        sop;
        logic        eop;
        logic [11:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tp_sig;
    logic        frame_start_in;
    logic        pix_valid_in;
    logic [11:0] pix_data_in;
    logic        ready_in;
    logic        valid_out;
    logic        startofpacket_out;
    logic        endofpacket_out;
    logic [11:0] data_out;
    logic        overflow_out;
    logic        frame_err_out;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t q[$];
    int   m_state;
    int   mx;
    int   my;
    bit   m_stray;
    bit   exp_ovf;
    bit   exp_err;
    logic [11:0] bars [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

    always #5 clk = ~clk;

    video_packet_framer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (12),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
`ifdef FRAMER_TEST_PATTERN_EN
        .test_pattern_in   (tp_sig),
`endif
        .frame_start_in    (frame_start_in),
        .pix_valid_in      (pix_valid_in),
        .pix_data_in       (pix_data_in),
        .ready_in          (ready_in),
        .valid_out         (valid_out),
        .startofpacket_out (startofpacket_out),
        .endofpacket_out   (endofpacket_out),
        .data_out          (data_out),
        .overflow_out      (overflow_out),
        .frame_err_out     (frame_err_out)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0;
        mx      = 0;
        my      = 0;
        m_stray = 1'b0;
        exp_ovf = 1'b0;
        exp_err = 1'b0;
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance model, then one clock.
    task automatic step(input bit fs, input bit pv, input logic [11:0] pd, input bit rdy, input bit tp);
        bit   counted;
        bit   stray;
        bit   drop;
        int   xc;
        int   yc;
        exp_t e;
        chk("valid", valid_out, q.size() != 0);
        chk("overflow", overflow_out, exp_ovf);
        chk("frame_err", frame_err_out, exp_err);
        if (q.size() != 0) begin
            chk("data", data_out, q[0].d);
            chk("sop", startofpacket_out, q[0].sop);
            chk("eop", endofpacket_out, q[0].eop);
        end
        frame_start_in = fs;
        pix_valid_in   = pv;
        pix_data_in    = pd;
        ready_in       = rdy;
        tp_sig         = tp;

        counted = pv && (m_state == 1 || fs);
        stray   = pv && !fs && (m_state != 1);
        xc      = fs ? 0 : mx;
        yc      = fs ? 0 : my;
        exp_err = (fs && m_state == 1) || (stray && !m_stray);
        drop    = 1'b0;
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (counted) begin
            e.sop = (xc == 0 && yc == 0);
            e.eop = (xc == W - 1 && yc == H - 1);
`ifdef FRAMER_TEST_PATTERN_EN
            e.d   = tp ? bars[xc / (W / 8)] : pd;
`else
            e.d   = pd;
`endif
            if (q.size() < DEPTH) q.push_back(e);
            else drop = 1'b1;
            if (xc == W - 1) begin
                mx = 0;
                my = (yc == H - 1) ? 0 : yc + 1;
            end else begin
                mx = xc + 1;
                my = yc;
            end
            m_state = (xc == W - 1 && yc == H - 1) ? 2 : 1;
        end else if (fs) begin
            mx      = 0;
            my      = 0;
            m_state = 1;
        end
        if (fs)         m_stray = 1'b0;
        else if (stray) m_stray = 1'b1;
        exp_ovf = drop;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 12'h000, 1, 0);
    endtask

    task automatic frame(input bit tp);
        step(1, 1, 12'($urandom), 1, tp);
        for (int i = 1; i < W * H; i++) step(0, 1, 12'($urandom), 1, tp);
    endtask

    initial begin
        rst_n          = 1'b0;
        tp_sig         = 1'b0;
        frame_start_in = 1'b0;
        pix_valid_in   = 1'b0;
        pix_data_in    = '0;
        ready_in       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_sop", startofpacket_out, 0);
        chk("rst_eop", endofpacket_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_overflow", overflow_out, 0);
        chk("rst_frame_err", frame_err_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Continuous frame, downstream always ready.
        frame(0);
        idle(4);

        // Eight-cycle downstream stall mid-line forces one dropped pixel.
        step(1, 1, 12'($urandom), 1, 0);
        for (int i = 1; i < W * H; i++)
            step(0, 1, 12'($urandom), !(i >= 20 && i < 28), 0);
        idle(12);

        // Short frame followed by a complete one.
        step(1, 1, 12'($urandom), 1, 0);
        for (int i = 1; i < 20; i++) step(0, 1, 12'($urandom), 1, 0);
        frame(0);

        // Five trailing stray pixels, then a frame whose start carries no pixel.
        for (int i = 0; i < 5; i++) step(0, 1, 12'($urandom), 1, 0);
        idle(3);
        step(1, 0, 12'h000, 1, 0);
        for (int i = 0; i < W * H; i++) step(0, 1, 12'($urandom), 1, 0);
        idle(4);

        // Asynchronous reset with a partly filled FIFO.
        step(1, 1, 12'($urandom), 0, 0);
        for (int i = 1; i < 5; i++) step(0, 1, 12'($urandom), 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", valid_out, 0);
        chk("async_rst_data", data_out, 0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 12'($urandom), 1, 0);
        frame(0);
        idle(4);

`ifdef FRAMER_TEST_PATTERN_EN
        frame(1);
        idle(4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_packet_framer.md
Name: video_packet_framer

Overview:
- Upstream neighbour of the blur/underage filter stage.
- Converts the free-running camera pixel stream (pixel valid plus frame-start pulse, no backpressure) into a 12-bit RGB444 packet stream with valid/ready, startofpacket and endofpacket.
- Absorbs short downstream stalls in a small FIFO.
- Flags dropped pixels and malformed frames.

Parameters:
- IMG_WIDTH, 320, pixels per line.
- IMG_HEIGHT, 240, lines per frame; frame = IMG_WIDTH*IMG_HEIGHT = 76800 pixels.
- DATA_W, 12, pixel width, RGB444 as {R[11:8],G[7:4],B[3:0]}.
- FIFO_DEPTH, 8, entries in the output FIFO; power of two, >=2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start_in  in  1  one-cycle pulse marking the start of a camera frame.
- pix_valid_in  in  1  pixel present on pix_data_in this cycle; cannot be stalled.
- pix_data_in  in  DATA_W  camera pixel.
- ready_in  in  1  downstream ready.
- valid_out  out  1  data_out/sop/eop valid.
- startofpacket_out  out  1  first pixel of frame.
- endofpacket_out  out  1  last pixel of frame.
- data_out  out  DATA_W  pixel.
- overflow_out  out  1  one-cycle pulse: pixel dropped, FIFO full.
- frame_err_out  out  1  one-cycle pulse: short or long frame detected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; state IDLE; x/y counters 0.
  - valid_out, startofpacket_out, endofpacket_out, overflow_out, frame_err_out = 0; data_out = 0.
- States:
  - IDLE: waiting for frame_start_in.
  - ACTIVE: counting pixels.
  - DONE: frame complete, waiting for next frame_start_in.
- IDLE -> ACTIVE on frame_start_in.
- ACTIVE -> DONE when the pixel with x=IMG_WIDTH-1, y=IMG_HEIGHT-1 is accepted.
- DONE -> ACTIVE on frame_start_in.
- Pixels are counted only in ACTIVE, or in the same cycle frame_start_in is seen.
- Counters:
  - x increments per counted pixel and wraps to 0 at IMG_WIDTH-1.
  - y increments on x wrap.
  - Both clear to 0 on frame_start_in.
- A pixel coinciding with frame_start_in is pixel 0 of the new frame.
- Tagging at FIFO write:
  - sop = (x==0 && y==0).
  - eop = (x==IMG_WIDTH-1 && y==IMG_HEIGHT-1).
- Short frame: frame_start_in in ACTIVE with count < 76800:
  - frame_err_out pulses next cycle; counters restart.
  - No eop is synthesised; downstream sees the next sop.
- Long frame: pix_valid_in while in DONE or IDLE:
  - pixel discarded.
  - frame_err_out pulses once per frame, on the first stray pixel only.
- FIFO is first-word-fall-through:
  - valid_out = !empty; pop on valid_out && ready_in.
  - Latency: pixel written in cycle N is visible on outputs in cycle N+1 when the FIFO was empty.
- Push while full without a simultaneous pop:
  - pixel dropped; overflow_out pulses next cycle.
  - Counters still advance, so frame geometry is preserved.
  - A dropped sop/eop marker is lost.
- Push and pop in the same cycle while full: push accepted; occupancy unchanged.
- Outputs are held stable while valid_out && !ready_in.
- Pixels exiting are never reordered or duplicated.

Optional Feature:
- Macro: FRAMER_TEST_PATTERN_EN.
- When defined:
  - Adds input test_pattern_in (1 bit).
  - While it is high, every counted pixel's data is replaced with 8 vertical colour bars selected by x/(IMG_WIDTH/8): 0xFFF, 0xFF0, 0x0FF, 0x0F0, 0xF0F, 0xF00, 0x00F, 0x000.
  - Framing, timing and overflow behaviour are unchanged.
- When undefined: the port is absent and data always comes from pix_data_in.

Decomposition:
- Package video_stream_pkg holds:
  - IMG_WIDTH/IMG_HEIGHT defaults.
  - typedef pixel_t (packed struct r,g,b, 4 bits each).
  - typedef framer_state_t enum {IDLE, ACTIVE, DONE}.
  - Colour-bar constant array.
- One sub-module: stream_fifo, a synchronous FWFT FIFO carrying {sop, eop, pixel_t}, with full/empty and async active-low reset.
- Counters, state machine and tagging stay in the top module.

Test Plan:
- Reset then frame_start + 76800 continuous pixels, ready_in=1:
  - valid_out follows one cycle later; sop on pixel 0, eop on pixel 76799.
  - No error pulses.
- Same frame with ready_in low for 8 cycles mid-line:
  - FIFO fills; the next pixel is dropped with overflow_out high for exactly 1 cycle.
  - Output order intact; data held stable during the stall.
- frame_start after 1000 pixels:
  - frame_err_out pulses once.
  - Next output pixel carries sop; no eop before it.
- 76805 pixels before next frame_start:
  - eop on pixel 76799.
  - 5 trailing pixels discarded; frame_err_out pulses once.
- rst_n asserted mid-frame with a non-empty FIFO:
  - valid_out=0 immediately (asynchronous).
  - Stray pixels are ignored until frame_start; then the first output carries sop.
- With FRAMER_TEST_PATTERN_EN and test_pattern_in=1:
  - Pixel x=0 gives data_out=0xFFF.
  - x=40 gives 0xFF0.
  - x=319 gives 0x000.
